// File: rtl/gpio_serial_loader.sv
// Serial loader for two GPIO pad configuration chains: fetches per-pad words and shifts them out MSB first.
// Optional macro SERIAL_CHAIN_RESET_EN adds serial_resetn and a chain reset phase before the first fetch.
module gpio_serial_loader #(
    parameter int unsigned AREA1PADS  = 19,
    parameter int unsigned TOTAL_PADS = 38,
    parameter int unsigned CFG_BITS   = 13,
    parameter int unsigned CLKDIV     = 4
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                xfer_start,
    output logic                busy,
    output logic                xfer_done,
    output logic [5:0]          cfg_addr1,
    output logic [5:0]          cfg_addr2,
    input  logic [CFG_BITS-1:0] cfg_data1,
    input  logic [CFG_BITS-1:0] cfg_data2,
    output logic                serial_clock,
    output logic                serial_load,
    output logic                serial_data_1,
    output logic                serial_data_2
`ifdef SERIAL_CHAIN_RESET_EN
    ,
    output logic                serial_resetn
`endif
);

    localparam int unsigned L1 = AREA1PADS;
    localparam int unsigned L2 = TOTAL_PADS - AREA1PADS;
    localparam int unsigned W  = (L1 > L2) ? L1 : L2;
    localparam int unsigned KW = (W > 1) ? $clog2(W) : 1;
    localparam int unsigned BW = $clog2(CFG_BITS + 1);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StShiftLo,
        StShiftHi,
        StLoadGap,
        StLoad,
        StDone
`ifdef SERIAL_CHAIN_RESET_EN
        ,
        StChainRst
`endif
    } state_e;

    state_e                r_state;
    state_e                w_state_next;
    logic [7:0]            r_phase;
    logic [BW-1:0]         r_bit;
    logic [KW-1:0]         r_k;
    logic [CFG_BITS-1:0]   r_sr1;
    logic [CFG_BITS-1:0]   r_sr2;

    logic                  w_ph_end;
    logic                  w_bit_last;
    logic                  w_k_last;
    logic                  w_act1;
    logic                  w_act2;
    logic                  w_phase_clr;
    logic [5:0]            w_addr1;
    logic [5:0]            w_addr2;

    assign w_ph_end   = (32'(r_phase) == CLKDIV - 1);
    assign w_bit_last = (32'(r_bit) == CFG_BITS - 1);
    assign w_k_last   = (32'(r_k) == W - 1);

    // The shorter chain is padded with leading zero words so both chains finish together.
    assign w_act1  = (32'(r_k) + L1 >= W);
    assign w_act2  = (32'(r_k) + L2 >= W);
    assign w_addr1 = 6'(W - 1 - 32'(r_k));
    assign w_addr2 = 6'(TOTAL_PADS - W + 32'(r_k));

    // State register
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (xfer_start) begin
`ifdef SERIAL_CHAIN_RESET_EN
                    w_state_next = StChainRst;
`else
                    w_state_next = StFetch;
`endif
                end
            end
`ifdef SERIAL_CHAIN_RESET_EN
            StChainRst: begin
                // Two CLKDIV halves keep the 8-bit phase counter from wrapping.
                if (w_ph_end && r_bit[0]) begin
                    w_state_next = StFetch;
                end
            end
`endif
            StFetch: begin
                if (r_phase[0]) begin
                    w_state_next = StShiftLo;
                end
            end
            StShiftLo: begin
                if (w_ph_end) begin
                    w_state_next = StShiftHi;
                end
            end
            StShiftHi: begin
                if (w_ph_end) begin
                    if (!w_bit_last) begin
                        w_state_next = StShiftLo;
                    end else if (w_k_last) begin
                        w_state_next = StLoadGap;
                    end else begin
                        w_state_next = StFetch;
                    end
                end
            end
            StLoadGap: begin
                if (w_ph_end) begin
                    w_state_next = StLoad;
                end
            end
            StLoad: begin
                if (w_ph_end) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

`ifdef SERIAL_CHAIN_RESET_EN
    assign w_phase_clr = (r_state == StIdle) || (w_state_next != r_state) ||
                         ((r_state == StChainRst) && w_ph_end);
`else
    assign w_phase_clr = (r_state == StIdle) || (w_state_next != r_state);
`endif

    // Counters and shift registers
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_phase <= '0;
            r_bit   <= '0;
            r_k     <= '0;
            r_sr1   <= '0;
            r_sr2   <= '0;
        end else begin
            if (w_phase_clr) begin
                r_phase <= '0;
            end else begin
                r_phase <= r_phase + 8'd1;
            end

            case (r_state)
                StIdle: begin
                    r_bit <= '0;
                    r_k   <= '0;
                end
`ifdef SERIAL_CHAIN_RESET_EN
                StChainRst: begin
                    if (w_ph_end) begin
                        r_bit <= r_bit[0] ? '0 : BW'(1);
                    end
                end
`endif
                StFetch: begin
                    if (r_phase[0]) begin
                        r_sr1 <= w_act1 ? cfg_data1 : '0;
                        r_sr2 <= w_act2 ? cfg_data2 : '0;
                    end
                end
                StShiftHi: begin
                    if (w_ph_end) begin
                        r_sr1 <= r_sr1 << 1;
                        r_sr2 <= r_sr2 << 1;
                        if (w_bit_last) begin
                            r_bit <= '0;
                            if (!w_k_last) begin
                                r_k <= r_k + KW'(1);
                            end
                        end else begin
                            r_bit <= r_bit + BW'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decode from state only, so an asynchronous reset clears them in the same cycle.
    always_comb begin
        busy          = 1'b0;
        xfer_done     = 1'b0;
        cfg_addr1     = 6'd0;
        cfg_addr2     = 6'd0;
        serial_clock  = 1'b0;
        serial_load   = 1'b0;
        serial_data_1 = 1'b0;
        serial_data_2 = 1'b0;
`ifdef SERIAL_CHAIN_RESET_EN
        serial_resetn = 1'b1;
`endif
        case (r_state)
`ifdef SERIAL_CHAIN_RESET_EN
            StChainRst: begin
                busy          = 1'b1;
                serial_resetn = 1'b0;
            end
`endif
            StFetch: begin
                busy      = 1'b1;
                cfg_addr1 = w_act1 ? w_addr1 : 6'd0;
                cfg_addr2 = w_act2 ? w_addr2 : 6'd0;
            end
            StShiftLo: begin
                busy          = 1'b1;
                serial_data_1 = r_sr1[CFG_BITS-1];
                serial_data_2 = r_sr2[CFG_BITS-1];
            end
            StShiftHi: begin
                busy          = 1'b1;
                serial_clock  = 1'b1;
                serial_data_1 = r_sr1[CFG_BITS-1];
                serial_data_2 = r_sr2[CFG_BITS-1];
            end
            StLoadGap: begin
                busy = 1'b1;
            end
            StLoad: begin
                busy        = 1'b1;
                serial_load = 1'b1;
            end
            StDone: begin
                xfer_done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_gpio_serial_loader.sv
// Scoreboard bench for gpio_serial_loader: 2+3 pads, 13-bit words, CLKDIV=2.
// Stimulus queues expected bits/done times; a negedge monitor pops and compares.
module tb_gpio_serial_loader;

    localparam int unsigned CLKDIV = 2;
`ifdef SERIAL_CHAIN_RESET_EN
    localparam int unsigned PRE = 2 * CLKDIV;
`else
    localparam int unsigned PRE = 0;
`endif
    // One word = 2 fetch + 2*2*13 shift cycles = 54; 1 + 3*54 + 2*2 = 167.
    localparam int unsigned WORD_CYC = 54;
    localparam int unsigned EXP_LEN  = 167 + PRE;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        xfer_start = 1'b0;
    logic        busy, xfer_done;
    logic [5:0]  cfg_addr1, cfg_addr2;
    logic [12:0] cfg_data1 = '0;
    logic [12:0] cfg_data2 = '0;
    logic        serial_clock, serial_load, serial_data_1, serial_data_2;
`ifdef SERIAL_CHAIN_RESET_EN
    logic        serial_resetn;
`endif

    gpio_serial_loader #(
        .AREA1PADS (2),
        .TOTAL_PADS(5),
        .CFG_BITS  (13),
        .CLKDIV    (CLKDIV)
    ) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .xfer_start   (xfer_start),
        .busy         (busy),
        .xfer_done    (xfer_done),
        .cfg_addr1    (cfg_addr1),
        .cfg_addr2    (cfg_addr2),
        .cfg_data1    (cfg_data1),
        .cfg_data2    (cfg_data2),
        .serial_clock (serial_clock),
        .serial_load  (serial_load),
        .serial_data_1(serial_data_1),
        .serial_data_2(serial_data_2)
`ifdef SERIAL_CHAIN_RESET_EN
        ,
        .serial_resetn(serial_resetn)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Config memory answers one cycle after the address; alt mode forces 0x1ABC on chain 1.
    bit alt_mode = 1'b0;
    always @(posedge clk) begin
        cfg_data1 <= alt_mode ? 13'h1ABC : (13'h1000 | 13'(cfg_addr1));
        cfg_data2 <= 13'h1000 | 13'(cfg_addr2);
    end

    int checks = 0;
    int errors = 0;
    bit exp_q1[$];
    bit exp_q2[$];
    int done_q[$];
    int load_q[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Chain 1 words: zero, pad 1, pad 0.  Chain 2 words: pad 2, 3, 4.
    task automatic start_xfer(input bit alt, output int c);
        logic [12:0] w1;
        logic [12:0] w2;
        alt_mode = alt;
        @(posedge clk);
        #1;
        xfer_start = 1'b1;
        c = cyc;
        for (int k = 0; k < 3; k++) begin
            if (k == 0)    w1 = 13'h0000;
            else if (alt)  w1 = 13'h1ABC;
            else if (k == 1) w1 = 13'h1001;
            else           w1 = 13'h1000;
            w2 = 13'h1002 + 13'(k);
            for (int b = 12; b >= 0; b--) begin
                exp_q1.push_back(w1[b]);
                exp_q2.push_back(w2[b]);
            end
        end
        done_q.push_back(c + int'(EXP_LEN));
        load_q.push_back(1);
        @(posedge clk);
        #1;
        xfer_start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
`ifdef SERIAL_CHAIN_RESET_EN
        chk("resetn_first", int'(serial_resetn), 0);
        repeat (2 * CLKDIV - 1) @(posedge clk);
        #1;
        chk("resetn_last", int'(serial_resetn), 0);
        @(posedge clk);
        #1;
        chk("resetn_release", int'(serial_resetn), 1);
        chk("first_addr2", int'(cfg_addr2), 2);
`endif
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1;
        xfer_start = 1'b1;
        @(posedge clk);
        #1;
        xfer_start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_q.size() != 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        chk("done_timeout", done_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Monitor
    bit prev_sclk = 1'b0;
    bit prev_load = 1'b0;
    bit held1, held2;
    int rise_cnt = 0;
    int last_fall = 0;
    int load_start = 0;

    always @(negedge clk) begin
        if (rst) begin
            prev_sclk = 1'b0;
            prev_load = 1'b0;
            rise_cnt  = 0;
        end else begin
            if (serial_clock && !prev_sclk) begin
                rise_cnt++;
                if (exp_q1.size() == 0 || exp_q2.size() == 0) begin
                    chk("extra_bit", 1, 0);
                end else begin
                    chk("sd1", int'(serial_data_1), int'(exp_q1.pop_front()));
                    chk("sd2", int'(serial_data_2), int'(exp_q2.pop_front()));
                end
                held1 = serial_data_1;
                held2 = serial_data_2;
            end else if (serial_clock) begin
                chk("sd1_hold", int'(serial_data_1), int'(held1));
                chk("sd2_hold", int'(serial_data_2), int'(held2));
            end
            if (!serial_clock && prev_sclk) last_fall = cyc;
            if (serial_load && !prev_load) begin
                if (load_q.size() == 0) begin
                    chk("unexpected_load", 1, 0);
                end else begin
                    void'(load_q.pop_front());
                    chk("load_delay", cyc - last_fall, int'(CLKDIV));
                end
                load_start = cyc;
            end
            if (!serial_load && prev_load) chk("load_len", cyc - load_start, int'(CLKDIV));
            if (xfer_done) begin
                if (done_q.size() == 0) chk("unexpected_done", 1, 0);
                else chk("done_cycle", cyc, done_q.pop_front());
                chk("rise_count", rise_cnt, 39);
                chk("busy_in_done", int'(busy), 0);
                rise_cnt = 0;
            end
            prev_sclk = serial_clock;
            prev_load = serial_load;
        end
    end

    task automatic chk_outs_zero(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(xfer_done), 0);
        chk({tag, "_sclk"}, int'(serial_clock), 0);
        chk({tag, "_sload"}, int'(serial_load), 0);
        chk({tag, "_sd1"}, int'(serial_data_1), 0);
        chk({tag, "_sd2"}, int'(serial_data_2), 0);
        chk({tag, "_addr1"}, int'(cfg_addr1), 0);
        chk({tag, "_addr2"}, int'(cfg_addr2), 0);
    endtask

    initial begin
        int c;
        int target;
        int n;
        repeat (3) @(posedge clk);
        #1;
        chk_outs_zero("reset");
`ifdef SERIAL_CHAIN_RESET_EN
        chk("reset_resetn", int'(serial_resetn), 1);
`endif
        rst = 1'b0;

        // Plain transfer
        start_xfer(1'b0, c);
        wait_done();

        // Starts while busy must be ignored
        start_xfer(1'b0, c);
        repeat (20) @(posedge clk);
        pulse_start();
        repeat (60) @(posedge clk);
        pulse_start();
        wait_done();
        repeat (200) @(posedge clk);
        #1;
        chk("idle_after_ignored_start", int'(busy), 0);

        // 0x1ABC on chain 1
        start_xfer(1'b1, c);
        wait_done();

        // Reset during the high phase of bit 7 of word 1
        start_xfer(1'b0, c);
        target = c + int'(PRE) + 1 + int'(WORD_CYC) + 2 + 15 * int'(CLKDIV);
        n = 0;
        while (cyc < target && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("reach_bit7", cyc, target);
        chk("pre_rst_sclk", int'(serial_clock), 1);
        rst = 1'b1;
        #1;
        chk_outs_zero("midrst");
        exp_q1.delete();
        exp_q2.delete();
        done_q.delete();
        load_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        chk("post_rst_idle", int'(busy), 0);

        // Recovery transfer
        start_xfer(1'b0, c);
        wait_done();

        repeat (10) @(posedge clk);
        #1;
        chk("bits_left_1", exp_q1.size(), 0);
        chk("bits_left_2", exp_q2.size(), 0);
        chk("loads_left", load_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
